// File: rtl/vid_out_stage_if.sv
// Video timing and colour bundle for the output stage.
// master: the upstream side; drives *_in, receives *_out.
// slave : the output stage; receives *_in, drives *_out.
//   hde/vde   horizontal / vertical display enables
//   hs/vs     syncs (inputs: 1 = active; outputs: after polarity select)
//   r/g/b     colour channels, RGB_hbit+1 bits each
//   vid_de    delayed hde & vde, for DVI encoders
interface vid_out_stage_if #(
  parameter int unsigned RGB_hbit = 7
);
  logic              hde_in;
  logic              vde_in;
  logic              hs_in;
  logic              vs_in;
  logic [RGB_hbit:0] r_in;
  logic [RGB_hbit:0] g_in;
  logic [RGB_hbit:0] b_in;

  logic              hde_out;
  logic              vde_out;
  logic              hs_out;
  logic              vs_out;
  logic              vid_de_out;
  logic [RGB_hbit:0] r_out;
  logic [RGB_hbit:0] g_out;
  logic [RGB_hbit:0] b_out;

  modport master (
    output hde_in, vde_in, hs_in, vs_in, r_in, g_in, b_in,
    input  hde_out, vde_out, hs_out, vs_out, vid_de_out, r_out, g_out, b_out
  );

  modport slave (
    input  hde_in, vde_in, hs_in, vs_in, r_in, g_in, b_in,
    output hde_out, vde_out, hs_out, vs_out, vid_de_out, r_out, g_out, b_out
  );
endinterface

// File: rtl/vid_out_stage.sv
// Video output stage: delays timing and RGB through PIPE_DEPTH pixel-rate
// stages, blanks colour outside the active area (black / border / pass),
// applies sync polarity, produces the DAC clock and counts frames.
// Ports:
//   pclk, reset      clock; synchronous active-high reset
//   pc_ena           pixel phase counter; a pixel advances when it is 0
//   vid              video bundle (slave modport)
//   mute_mode        0 black, 1 border colour, 2/3 pass-through
//   border_r/g/b     border colour
//   vid_clk          registered (pc_ena >= VCLK_PHASE)
//   frame_cnt        count of raw vs rising edges seen at pixel strobes
module vid_out_stage #(
  parameter int unsigned RGB_hbit   = 7,
  parameter int unsigned PIPE_DEPTH = 1,
  parameter bit          HS_invert  = 1'b1,
  parameter bit          VS_invert  = 1'b1,
  parameter int unsigned VCLK_PHASE = 3
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic [3:0]        pc_ena,
  vid_out_stage_if.slave    vid,
  input  logic [1:0]        mute_mode,
  input  logic [RGB_hbit:0] border_r,
  input  logic [RGB_hbit:0] border_g,
  input  logic [RGB_hbit:0] border_b,
  output logic              vid_clk,
  output logic [15:0]       frame_cnt
);

  typedef enum logic [1:0] {
    MUTE_BLACK    = 2'd0,
    MUTE_BORDER   = 2'd1,
    MUTE_PASS     = 2'd2,
    MUTE_PASS_ALT = 2'd3
  } mute_e;

  typedef struct packed {
    logic              hde;
    logic              vde;
    logic              hs;
    logic              vs;
    logic              de;
    logic [RGB_hbit:0] r;
    logic [RGB_hbit:0] g;
    logic [RGB_hbit:0] b;
  } stage_t;

  // Sync stages idle at the inactive output level, not at 0.
  localparam stage_t STAGE_RST = '{hde: 1'b0, vde: 1'b0, hs: HS_invert,
                                   vs: VS_invert, de: 1'b0,
                                   r: '0, g: '0, b: '0};
  localparam logic [3:0] VCLK_TH = 4'(VCLK_PHASE);

  logic   ps;
  mute_e  mode;
  stage_t cap;
  stage_t pipe [PIPE_DEPTH];
  logic   vs_prev;

  assign ps   = (pc_ena == 4'd0);
  assign mode = mute_e'(mute_mode);

  always_comb begin
    cap     = STAGE_RST;
    cap.hde = vid.hde_in;
    cap.vde = vid.vde_in;
    cap.hs  = vid.hs_in ^ HS_invert;
    cap.vs  = vid.vs_in ^ VS_invert;
    cap.de  = vid.hde_in & vid.vde_in;
    if (cap.de) begin
      cap.r = vid.r_in;
      cap.g = vid.g_in;
      cap.b = vid.b_in;
    end else begin
      unique case (mode)
        MUTE_BLACK: begin
          cap.r = '0;
          cap.g = '0;
          cap.b = '0;
        end
        MUTE_BORDER: begin
          cap.r = border_r;
          cap.g = border_g;
          cap.b = border_b;
        end
        MUTE_PASS, MUTE_PASS_ALT: begin
          cap.r = vid.r_in;
          cap.g = vid.g_in;
          cap.b = vid.b_in;
        end
        default: begin
          cap.r = vid.r_in;
          cap.g = vid.g_in;
          cap.b = vid.b_in;
        end
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) pipe[i] <= STAGE_RST;
    end else if (ps) begin
      pipe[0] <= cap;
      for (int unsigned i = 1; i < PIPE_DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Edge detect on the raw input so the count is independent of polarity
  // and of pipeline depth.
  always_ff @(posedge pclk) begin
    if (reset) begin
      vs_prev   <= 1'b0;
      frame_cnt <= '0;
    end else if (ps) begin
      vs_prev <= vid.vs_in;
      if (vid.vs_in && !vs_prev) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) vid_clk <= 1'b0;
    else       vid_clk <= (pc_ena >= VCLK_TH);
  end

  assign vid.hde_out    = pipe[PIPE_DEPTH-1].hde;
  assign vid.vde_out    = pipe[PIPE_DEPTH-1].vde;
  assign vid.hs_out     = pipe[PIPE_DEPTH-1].hs;
  assign vid.vs_out     = pipe[PIPE_DEPTH-1].vs;
  assign vid.vid_de_out = pipe[PIPE_DEPTH-1].de;
  assign vid.r_out      = pipe[PIPE_DEPTH-1].r;
  assign vid.g_out      = pipe[PIPE_DEPTH-1].g;
  assign vid.b_out      = pipe[PIPE_DEPTH-1].b;

endmodule

// File: tb/tb_vid_out_stage.sv
`timescale 1ns/1ps
module tb_vid_out_stage;
  localparam int D = 3;

  typedef struct packed {
    logic       hde;
    logic       vde;
    logic       hs;
    logic       vs;
    logic       de;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } ovec_t;

  // hs_out idles high (HS_invert=1), vs_out idles low (VS_invert=0).
  localparam ovec_t RST_V = '{hde: 1'b0, vde: 1'b0, hs: 1'b1, vs: 1'b0,
                              de: 1'b0, r: 8'h00, g: 8'h00, b: 8'h00};

  logic        pclk;
  logic        reset;
  logic [3:0]  pc_ena;
  logic [1:0]  mute_mode;
  logic [7:0]  border_r, border_g, border_b;
  logic        vid_clk;
  logic [15:0] frame_cnt;

  vid_out_stage_if #(.RGB_hbit(7)) vif ();

  vid_out_stage #(
    .RGB_hbit(7), .PIPE_DEPTH(D), .HS_invert(1'b1), .VS_invert(1'b0),
    .VCLK_PHASE(2)
  ) dut (
    .pclk(pclk), .reset(reset), .pc_ena(pc_ena), .vid(vif),
    .mute_mode(mute_mode), .border_r(border_r), .border_g(border_g),
    .border_b(border_b), .vid_clk(vid_clk), .frame_cnt(frame_cnt)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  ovec_t       q[$];
  ovec_t       cur_exp;
  logic [15:0] exp_cnt;
  logic        vs_prev_m;
  int          total;
  int          bad;
  string       tag;

  function automatic ovec_t capture();
    ovec_t v;
    v.hde = vif.hde_in;
    v.vde = vif.vde_in;
    v.hs  = ~vif.hs_in;
    v.vs  = vif.vs_in;
    v.de  = vif.hde_in & vif.vde_in;
    if (v.de) begin
      v.r = vif.r_in; v.g = vif.g_in; v.b = vif.b_in;
    end else if (mute_mode == 2'd0) begin
      v.r = 8'h00; v.g = 8'h00; v.b = 8'h00;
    end else if (mute_mode == 2'd1) begin
      v.r = border_r; v.g = border_g; v.b = border_b;
    end else begin
      v.r = vif.r_in; v.g = vif.g_in; v.b = vif.b_in;
    end
    return v;
  endfunction

  // One pclk cycle: update the reference model from the inputs present
  // before the edge, clock, then compare the DUT against it.
  task automatic step(input bit chk);
    ovec_t obs;
    logic  exp_vclk;
    exp_vclk = !reset && (pc_ena >= 4'd2);
    if (reset) begin
      q.delete();
      cur_exp   = RST_V;
      exp_cnt   = 16'h0000;
      vs_prev_m = 1'b0;
    end else if (pc_ena == 4'd0) begin
      q.push_back(capture());
      if (vif.vs_in && !vs_prev_m) exp_cnt = exp_cnt + 16'd1;
      vs_prev_m = vif.vs_in;
      if (q.size() == D) cur_exp = q.pop_front();
    end
    @(posedge pclk);
    #1;
    if (chk) begin
      obs = {vif.hde_out, vif.vde_out, vif.hs_out, vif.vs_out, vif.vid_de_out,
             vif.r_out, vif.g_out, vif.b_out};
      total++;
      assert (obs === cur_exp) else begin
        bad++;
        $error("FAIL %s.video got=%h exp=%h", tag, obs, cur_exp);
      end
      total++;
      assert (frame_cnt === exp_cnt) else begin
        bad++;
        $error("FAIL %s.frame_cnt got=%h exp=%h", tag, frame_cnt, exp_cnt);
      end
      total++;
      assert (vid_clk === exp_vclk) else begin
        bad++;
        $error("FAIL %s.vid_clk got=%b exp=%b", tag, vid_clk, exp_vclk);
      end
    end
  endtask

  task automatic chk_cnt(input string name, input logic [15:0] want);
    total++;
    assert (frame_cnt === want) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", name, frame_cnt, want);
    end
  endtask

  task automatic set_pix(input logic h, input logic v, input logic hs,
                         input logic vs, input logic [7:0] r,
                         input logic [7:0] g, input logic [7:0] b);
    vif.hde_in = h; vif.vde_in = v; vif.hs_in = hs; vif.vs_in = vs;
    vif.r_in = r; vif.g_in = g; vif.b_in = b;
  endtask

  // Full pixel period with pc_ena 0..3; colour is scrambled on the
  // non-strobe phases, which must not be captured.
  task automatic pixel(input logic h, input logic v, input logic hs,
                       input logic vs, input logic [7:0] r,
                       input logic [7:0] g, input logic [7:0] b);
    set_pix(h, v, hs, vs, r, g, b);
    for (int p = 0; p < 4; p++) begin
      pc_ena = 4'(p);
      if (p != 0) begin
        vif.r_in = 8'($urandom); vif.g_in = 8'($urandom); vif.b_in = 8'($urandom);
      end
      step(1'b1);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    cur_exp = RST_V; exp_cnt = '0; vs_prev_m = 1'b0;
    reset = 1'b1; pc_ena = 4'd0; mute_mode = 2'd0;
    border_r = 8'h00; border_g = 8'h00; border_b = 8'h00;
    set_pix(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

    tag = "reset";
    step(1'b1);
    step(1'b1);
    chk_cnt("reset.cnt0", 16'h0000);
    reset = 1'b0;

    tag = "latency";
    pixel(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    pixel(1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h5A, 8'hC3);
    for (int i = 0; i < 4; i++) pixel(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

    tag = "blank";
    border_r = 8'h40; border_g = 8'h50; border_b = 8'h60;
    for (int m = 0; m < 3; m++) begin
      mute_mode = 2'(m);
      for (int i = 0; i < 2; i++) pixel(1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 8'h22, 8'h33);
    end
    for (int i = 0; i < 3; i++) pixel(1'b1, 1'b1, 1'b1, 1'b0, 8'h77, 8'h88, 8'h99);

    tag = "random";
    for (int i = 0; i < 40; i++) begin
      mute_mode = 2'($urandom_range(0, 3));
      border_r = 8'($urandom); border_g = 8'($urandom); border_b = 8'($urandom);
      pixel(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            8'($urandom), 8'($urandom), 8'($urandom));
    end

    tag = "hold";
    pc_ena = 4'd2;
    for (int i = 0; i < 20; i++) begin
      set_pix(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              8'($urandom), 8'($urandom), 8'($urandom));
      step(1'b1);
    end

    tag = "midreset";
    mute_mode = 2'd2;
    pixel(1'b1, 1'b1, 1'b1, 1'b1, 8'hDE, 8'hAD, 8'hBE);
    pixel(1'b1, 1'b1, 1'b0, 1'b0, 8'hEF, 8'h01, 8'h02);
    pc_ena = 4'd1;
    reset = 1'b1;
    step(1'b1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) pixel(1'b1, 1'b1, 1'b0, 1'b0, 8'h12, 8'h34, 8'h56);

    tag = "frame";
    reset = 1'b1; pc_ena = 4'd0;
    step(1'b1);
    reset = 1'b0;
    set_pix(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 65535; i++) begin
      vif.vs_in = 1'b1; step(1'b0);
      vif.vs_in = 1'b0; step(1'b0);
    end
    step(1'b1);
    chk_cnt("frame.preload", 16'hFFFF);
    vif.vs_in = 1'b1; step(1'b1);
    chk_cnt("frame.wrap", 16'h0000);
    vif.vs_in = 1'b0; step(1'b1);
    vif.vs_in = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b1);
    chk_cnt("frame.held_high", 16'h0001);
    vif.vs_in = 1'b0; step(1'b1);
    pc_ena = 4'd1; vif.vs_in = 1'b1; step(1'b1);
    pc_ena = 4'd2; vif.vs_in = 1'b0; step(1'b1);
    pc_ena = 4'd0; step(1'b1);
    pc_ena = 4'd3; step(1'b1);
    chk_cnt("frame.nonps_edge", 16'h0001);

    tag = "reset_vs";
    pc_ena = 4'd0; vif.vs_in = 1'b1; reset = 1'b1;
    step(1'b1);
    chk_cnt("reset_vs.cnt", 16'h0000);
    reset = 1'b0;
    step(1'b1);
    chk_cnt("reset_vs.after", 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
